// File: rtl/frame_reader_pkg.sv
// Shared types and defaults for the frame reader: FSM state encoding,
// default image geometry and a width helper that stays at least 1 bit.
package frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  // Degenerate geometries (a single pixel/row/column) still need a 1-bit counter.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_out_fifo.sv
// Two-entry output FIFO: head register drives the stream directly, tail
// register absorbs the one extra beat that can be in flight during a stall.
module frame_out_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;

  // NOTE: payload registers carry no reset; every consumer qualifies them with count.
  always_ff @(posedge clk) begin
    if (push && pop) begin
      if (count_q == 2'd2) begin
        head_q <= tail_q;
        tail_q <= din;
      end else begin
        head_q <= din;
      end
    end else if (push) begin
      if (count_q == 2'd0) head_q <= din;
      else                 tail_q <= din;
    end else if (pop) begin
      head_q <= tail_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= 2'd0;
    end else if (push && !pop) begin
      count_q <= count_q + 2'd1;
    end else if (pop && !push) begin
      count_q <= count_q - 2'd1;
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/frame_reader.sv
// Streams one IMG_W x IMG_H frame from a 1-cycle-latency memory onto a
// valid/ready stream. Define FRAME_READER_MARKERS_EN to generate m_user/m_last.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int IMG_W  = IMG_W_DEF,
  parameter  int IMG_H  = IMG_H_DEF,
  localparam int ADDR_W = safe_clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_user,
  output logic              m_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  state_t            state, state_next;
  logic              inflight;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        count;
  logic [2:0]        occupancy;
  logic              pop;
  logic              accept;

  assign accept    = (state == IDLE) && start;
  assign pop       = m_valid && m_ready;
  assign occupancy = 3'(inflight) + 3'(count) - 3'(pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    if (mem_rd_en && (addr == LAST_ADDR)) state_next = DRAIN;
      DRAIN:   if (!inflight && (count == 2'd0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DRAIN) && !inflight && (count == 2'd0);
    mem_rd_en = (state == READ) && (occupancy < 3'd2);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_rd_en;
      if (accept)         addr <= '0;
      else if (mem_rd_en) addr <= addr + 1'b1;
    end
  end

  assign mem_addr = addr;
  assign m_valid  = (count != 2'd0);

`ifdef FRAME_READER_MARKERS_EN
  localparam int COL_W = safe_clog2(IMG_W);
  localparam int ROW_W = safe_clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               inflight_user;
  logic               inflight_last;
  logic [WIDTH+1:0]   fifo_head;

  // Markers are decided when the address is issued and travel with the read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col           <= '0;
      row           <= '0;
      inflight_user <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight_user <= (row == '0) && (col == '0);
      inflight_last <= (col == COL_LAST);
      if (accept) begin
        col <= '0;
        row <= '0;
      end else if (mem_rd_en) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  frame_out_fifo #(.WIDTH(WIDTH + 2)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inflight),
    .pop   (pop),
    .din   ({inflight_user, inflight_last, mem_rd_data}),
    .head  (fifo_head),
    .count (count)
  );

  assign m_data = fifo_head[WIDTH-1:0];
  assign m_user = m_valid && fifo_head[WIDTH+1];
  assign m_last = m_valid && fifo_head[WIDTH];
`else
  frame_out_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inflight),
    .pop   (pop),
    .din   (mem_rd_data),
    .head  (m_data),
    .count (count)
  );

  assign m_user = 1'b0;
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader on a 4x2 frame with memory[a] = a+16, checked
// against a pixel-index model under steady, stalled, toggled and random ready.
module tb_frame_reader;

  localparam int WIDTH  = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int N      = IMG_W * IMG_H;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_rd_data;
  logic [WIDTH-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_user;
  logic              m_last;

  frame_reader #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_user      (m_user),
    .m_last      (m_last)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [N];
  initial for (int a = 0; a < N; a++) mem[a] = WIDTH'(a + 16);
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [WIDTH+1:0] beats[$];
  int beat_cyc[$];
  int addrs[$];
  int issue_cyc[$];
  int done_cnt, done_cyc, first_valid_cyc, max_occ, unstable, stall_bad, stall_seen;

  // Reference: pixel i carries value i+16, SOF on pixel 0, EOL on the last column.
  function automatic logic [WIDTH+1:0] exp_beat(input int i);
    logic u, l;
    u = 1'b0;
    l = 1'b0;
`ifdef FRAME_READER_MARKERS_EN
    u = (i == 0);
    l = ((i % IMG_W) == IMG_W - 1);
`endif
    return {u, l, WIDTH'(i + 16)};
  endfunction

  // mode 0: ready high, 1: 6-cycle stall with pixel 2 at the head,
  // 2: ready 1,0,1,0..., 3: random ready. Ends 4 cycles after done or at budget.
  task automatic collect(input int mode, input bit second_start, input int budget);
    int cyc, popped, issued, extra, stall_left, occ;
    bit prev_hold;
    logic [WIDTH+1:0] prev_out;
    beats.delete(); beat_cyc.delete(); addrs.delete(); issue_cyc.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; max_occ = 0;
    unstable = 0; stall_bad = 0; stall_seen = 0;
    cyc = 0; popped = 0; issued = 0; extra = 0; stall_left = 6; prev_hold = 1'b0;
    prev_out = '0;
    @(negedge clk);
    start = 1'b1;
    m_ready = 1'b0;
    while (cyc < budget && extra < 4) begin
      @(negedge clk);
      cyc++;
      start = second_start && (cyc == 3);
      case (mode)
        0: m_ready = 1'b1;
        1: if (popped == 2 && stall_left > 0) begin m_ready = 1'b0; stall_left--; end
           else m_ready = 1'b1;
        2: m_ready = cyc[0];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (mem_rd_en) begin addrs.push_back(int'(mem_addr)); issue_cyc.push_back(cyc); end
      occ = issued - popped + int'(mem_rd_en) - int'(m_valid && m_ready);
      if (occ > max_occ) max_occ = occ;
      if (prev_hold && (!m_valid || {m_user, m_last, m_data} != prev_out)) unstable++;
      if (mode == 1 && !m_ready && m_valid) begin
        stall_seen++;
        if (m_data !== 8'd18) stall_bad++;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        beats.push_back({m_user, m_last, m_data});
        beat_cyc.push_back(cyc);
        popped++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      issued += int'(mem_rd_en);
      prev_hold = m_valid && !m_ready;
      prev_out  = {m_user, m_last, m_data};
      if (done_cnt > 0) extra++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, mem_rd_en, m_valid, m_user, m_last} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000", {busy, done, mem_rd_en, m_valid, m_user, m_last});
    else pass_cnt++;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, mem_rd_en, m_valid} !== 3'b0)
      $display("FAIL idle_after_reset: got %b expected 000", {busy, mem_rd_en, m_valid});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    collect(0, 1'b0, 60);
    total_cnt++;
    if (issue_cyc.size() != N) $display("FAIL basic_issue_count: got %0d expected %0d", issue_cyc.size(), N);
    else pass_cnt++;
    for (int i = 0; i < issue_cyc.size() && i < N; i++) begin
      total_cnt++;
      if (addrs[i] != i || issue_cyc[i] != i + 1)
        $display("FAIL basic_issue%0d: got addr %0d at cycle %0d expected addr %0d at cycle %0d", i, addrs[i], issue_cyc[i], i, i + 1);
      else pass_cnt++;
    end
    total_cnt++;
    if (first_valid_cyc != 3) $display("FAIL basic_latency: got m_valid at cycle %0d expected 3", first_valid_cyc);
    else pass_cnt++;
    total_cnt++;
    if (beats.size() != N) $display("FAIL basic_beat_count: got %0d expected %0d", beats.size(), N);
    else pass_cnt++;
    for (int i = 0; i < beats.size() && i < N; i++) begin
      total_cnt++;
      if (beats[i] !== exp_beat(i) || beat_cyc[i] != i + 3)
        $display("FAIL basic_beat%0d: got %h at cycle %0d expected %h at cycle %0d", i, beats[i], beat_cyc[i], exp_beat(i), i + 3);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cnt != 1 || done_cyc != N + 3)
      $display("FAIL basic_done: got %0d pulses at cycle %0d expected 1 at cycle %0d", done_cnt, done_cyc, N + 3);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    collect(1, 1'b0, 80);
    total_cnt++;
    if (beats.size() != N) $display("FAIL bp_beat_count: got %0d expected %0d", beats.size(), N);
    else pass_cnt++;
    for (int i = 0; i < beats.size() && i < N; i++) begin
      total_cnt++;
      if (beats[i] !== exp_beat(i)) $display("FAIL bp_beat%0d: got %h expected %h", i, beats[i], exp_beat(i));
      else pass_cnt++;
    end
    total_cnt++;
    if (stall_seen != 6 || stall_bad != 0)
      $display("FAIL bp_stall_hold: got %0d stalled cycles, %0d not at 18, expected 6 and 0", stall_seen, stall_bad);
    else pass_cnt++;
    total_cnt++;
    if (max_occ > 2 || unstable != 0 || done_cnt != 1)
      $display("FAIL bp_flow: got occupancy %0d unstable %0d done %0d expected <=2 0 1", max_occ, unstable, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_toggle();
    collect(2, 1'b0, 80);
    total_cnt++;
    if (beats.size() != N) $display("FAIL toggle_beat_count: got %0d expected %0d", beats.size(), N);
    else pass_cnt++;
    for (int i = 0; i < beats.size() && i < N; i++) begin
      total_cnt++;
      if (beats[i] !== exp_beat(i)) $display("FAIL toggle_beat%0d: got %h expected %h", i, beats[i], exp_beat(i));
      else pass_cnt++;
    end
    total_cnt++;
    if (max_occ > 2 || unstable != 0 || done_cnt != 1)
      $display("FAIL toggle_flow: got occupancy %0d unstable %0d done %0d expected <=2 0 1", max_occ, unstable, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      collect(3, 1'b0, 200);
      total_cnt++;
      if (beats.size() != N) $display("FAIL rand%0d_beat_count: got %0d expected %0d", r, beats.size(), N);
      else pass_cnt++;
      for (int i = 0; i < beats.size() && i < N; i++) begin
        total_cnt++;
        if (beats[i] !== exp_beat(i)) $display("FAIL rand%0d_beat%0d: got %h expected %h", r, i, beats[i], exp_beat(i));
        else pass_cnt++;
      end
      total_cnt++;
      if (max_occ > 2 || unstable != 0 || done_cnt != 1)
        $display("FAIL rand%0d_flow: got occupancy %0d unstable %0d done %0d expected <=2 0 1", r, max_occ, unstable, done_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_double_start();
    collect(0, 1'b1, 60);
    total_cnt++;
    if (beats.size() != N || done_cnt != 1)
      $display("FAIL double_start: got %0d beats %0d done expected %0d beats 1 done", beats.size(), done_cnt, N);
    else pass_cnt++;
    for (int i = 0; i < beats.size() && i < N; i++) begin
      total_cnt++;
      if (beats[i] !== exp_beat(i)) $display("FAIL double_start_beat%0d: got %h expected %h", i, beats[i], exp_beat(i));
      else pass_cnt++;
    end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL double_start_idle: got busy %b expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int nb, cyc;
    nb = 0; cyc = 0;
    @(negedge clk);
    start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    while (cyc < 40) begin
      if (m_valid && m_ready) begin
        if (nb == 4) break;
        nb++;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    total_cnt++;
    if (nb != 4 || m_data !== 8'd20) $display("FAIL midreset_reach_beat4: got %0d beats head %0d expected 4 head 20", nb, m_data);
    else pass_cnt++;
    rstn = 1'b0;
    #1;
    total_cnt++;
    if ({m_valid, busy, mem_rd_en, m_user, m_last} !== 5'b0)
      $display("FAIL midreset_async: got %b expected 00000", {m_valid, busy, mem_rd_en, m_user, m_last});
    else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++;
    if ({busy, m_valid, mem_rd_en} !== 3'b0)
      $display("FAIL midreset_wait_idle: got %b expected 000", {busy, m_valid, mem_rd_en});
    else pass_cnt++;
    collect(0, 1'b0, 60);
    total_cnt++;
    if (beats.size() != N || done_cnt != 1)
      $display("FAIL midreset_frame: got %0d beats %0d done expected %0d beats 1 done", beats.size(), done_cnt, N);
    else pass_cnt++;
    for (int i = 0; i < beats.size() && i < N; i++) begin
      total_cnt++;
      if (beats[i] !== exp_beat(i)) $display("FAIL midreset_beat%0d: got %h expected %h", i, beats[i], exp_beat(i));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle();
    test_random();
    test_double_start();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
